// File: rtl/lighthouse_readout_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the lighthouse readout arbiter.
package lighthouse_pkg;

   localparam int SENSOR_ID_W = 4;
   localparam int MAX_SENSORS = 16;
   localparam int LH_DATA_W   = 32;

   typedef struct packed {
      logic [SENSOR_ID_W-1:0] id;
      logic [LH_DATA_W-1:0]   data;
   } lh_entry_t;

   typedef struct packed {
      logic                   found;
      logic [SENSOR_ID_W-1:0] index;
   } rr_pick_t;

   // Scans from the highest offset down so the lowest offset from ptr wins.
   function automatic rr_pick_t rr_pick(input logic [MAX_SENSORS-1:0] pending,
                                        input logic [SENSOR_ID_W-1:0] ptr,
                                        input int                     n);
      rr_pick_t r;
      int       idx;
      r = '0;
      for (int k = MAX_SENSORS - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (pending[idx]) begin
               r.found = 1'b1;
               r.index = SENSOR_ID_W'(idx);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lighthouse_readout_arbiter_fifo.sv
// First-word fall-through FIFO; head is visible combinationally and reads zero when empty.
module lighthouse_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_reg;
   assign dout    = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/lighthouse_readout_arbiter.sv
// Latches decoder samples per sensor and round-robins them into one FWFT readout FIFO.
// Optional saturating overrun counter is built when LH_OVERRUN_COUNT_EN is defined.
module lighthouse_readout_arbiter
   import lighthouse_pkg::*;
#(
   parameter int N_SENSORS  = 16,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [N_SENSORS*DATA_W-1:0]   sensor_data,
   input  logic [N_SENSORS-1:0]          data_ready,
   input  logic [N_SENSORS-1:0]          enable_mask,
   input  logic                          pop,
   output logic                          out_valid,
   output logic [3:0]                    out_id,
   output logic [DATA_W-1:0]             out_data,
`ifdef LH_OVERRUN_COUNT_EN
   output logic [15:0]                   overrun_cnt,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

   localparam int ENTRY_W = SENSOR_ID_W + DATA_W;

   logic [N_SENSORS-1:0]   data_ready_q;
   logic [N_SENSORS-1:0]   pending;
   logic [N_SENSORS-1:0]   rise;
   logic [N_SENSORS-1:0]   grant_onehot;
   logic [DATA_W-1:0]      hold [N_SENSORS];
   logic [SENSOR_ID_W-1:0] rr_ptr_reg;
   logic [SENSOR_ID_W-1:0] grant_id;
   logic [MAX_SENSORS-1:0] pending_ext;
   rr_pick_t               pick;
   logic                   grant_valid;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [ENTRY_W-1:0]     fifo_din;
   logic [ENTRY_W-1:0]     fifo_dout;

   assign rise        = data_ready & ~data_ready_q & enable_mask;
   assign pending_ext = MAX_SENSORS'(pending);
   assign pick        = rr_pick(pending_ext, rr_ptr_reg, N_SENSORS);
   assign grant_valid = pick.found & ~fifo_full;
   assign grant_id    = pick.index;
   // The pushed word is the registered sample, so a same-cycle rise loads the next one.
   assign fifo_din    = {grant_id, hold[grant_id]};

   genvar gi;
   generate
      for (gi = 0; gi < N_SENSORS; gi++) begin : g_sensor
         logic [DATA_W-1:0] hold_reg;
         logic              pending_reg;

         assign grant_onehot[gi] = grant_valid && (grant_id == SENSOR_ID_W'(gi));
         assign hold[gi]         = hold_reg;
         assign pending[gi]      = pending_reg;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               hold_reg    <= '0;
               pending_reg <= 1'b0;
            end else if (rise[gi]) begin
               hold_reg    <= sensor_data[gi*DATA_W +: DATA_W];
               pending_reg <= 1'b1;
            end else if (grant_onehot[gi]) begin
               pending_reg <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_ready_q <= '0;
         rr_ptr_reg   <= '0;
      end else begin
         data_ready_q <= data_ready;
         if (grant_valid)
            rr_ptr_reg <= (grant_id == SENSOR_ID_W'(N_SENSORS - 1)) ? '0 : grant_id + 1'b1;
      end
   end

`ifdef LH_OVERRUN_COUNT_EN
   logic [N_SENSORS-1:0] overrun_hits;
   logic [15:0]          overrun_cnt_reg;
   logic [16:0]          overrun_sum;

   assign overrun_hits = rise & pending & ~grant_onehot;
   assign overrun_sum  = {1'b0, overrun_cnt_reg} + 17'($countones(overrun_hits));
   assign overrun_cnt  = overrun_cnt_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) overrun_cnt_reg <= '0;
      else       overrun_cnt_reg <= overrun_sum[16] ? 16'hFFFF : overrun_sum[15:0];
   end
`endif

   lighthouse_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (grant_valid),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fill_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign out_id    = fifo_dout[ENTRY_W-1 -: SENSOR_ID_W];
   assign out_data  = fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_lighthouse_readout_arbiter.sv
// Scoreboard bench: stimulus queues expected FIFO entries, a negedge monitor checks each pop.
module tb_lighthouse_readout_arbiter;
   import lighthouse_pkg::*;

   localparam int N  = 16;
   localparam int DW = 32;
   localparam int FD = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic [N*DW-1:0]   sensor_data;
   logic [N-1:0]      data_ready;
   logic [N-1:0]      enable_mask;
   logic              pop;
   logic              out_valid;
   logic [3:0]        out_id;
   logic [DW-1:0]     out_data;
   logic [5:0]        fill_level;
`ifdef LH_OVERRUN_COUNT_EN
   logic [15:0]       overrun_cnt;
`endif

   int tests  = 0;
   int failed = 0;
   lh_entry_t exp_q[$];

   lighthouse_readout_arbiter #(.N_SENSORS(N), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
      .clock       (clock),
      .reset       (reset),
      .sensor_data (sensor_data),
      .data_ready  (data_ready),
      .enable_mask (enable_mask),
      .pop         (pop),
      .out_valid   (out_valid),
      .out_id      (out_id),
      .out_data    (out_data),
`ifdef LH_OVERRUN_COUNT_EN
      .overrun_cnt (overrun_cnt),
`endif
      .fill_level  (fill_level)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   task automatic set_sd(input int s, input logic [31:0] v);
      sensor_data[s*DW +: DW] = v;
   endtask

   task automatic exp_push(input int s, input logic [31:0] v);
      lh_entry_t e;
      e.id   = 4'(s);
      e.data = v;
      exp_q.push_back(e);
   endtask

   // One-cycle rise on a single sensor, followed by the edge on which it can be granted.
   task automatic rise_one(input int s, input logic [31:0] v);
      set_sd(s, v);
      data_ready = 16'(1) << s;
      tick();
      data_ready = '0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pop_one();
      pop = 1'b1;
      at_neg();
      tick();
      pop = 1'b0;
   endtask

   task automatic drain(input int budget);
      pop = 1'b1;
      for (int i = 0; i < budget; i++) begin
         at_neg();
         if (!out_valid) break;
         tick();
      end
      pop = 1'b0;
      at_neg();
      check("drain_empty", 64'(out_valid), 64'd0);
      check("drain_scoreboard_left", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every accepted pop must match the oldest expected entry.
   always @(negedge clock) begin
      if (!reset && pop && out_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL head_unexpected: got id=%0d data=%0h required none", out_id, out_data);
         end else begin
            lh_entry_t e;
            e = exp_q.pop_front();
            check("head_id", 64'(out_id), 64'(e.id));
            check("head_data", 64'(out_data), 64'(e.data));
         end
      end
   end

   initial begin
      reset       = 1'b1;
      sensor_data = '0;
      data_ready  = '0;
      enable_mask = '1;
      pop         = 1'b0;
      repeat (3) tick();

      // 1: reset state and pop while empty
      at_neg();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_id", 64'(out_id), 64'd0);
      tick();
      reset = 1'b0;
      pop   = 1'b1;
      tick();
      tick();
      pop = 1'b0;
      at_neg();
      check("empty_pop_fill", 64'(fill_level), 64'd0);
      check("empty_pop_valid", 64'(out_valid), 64'd0);

      // 2: single sample latency
      tick();
      set_sd(2, 32'h0001_2345);
      data_ready = 16'h0004;
      exp_push(2, 32'h0001_2345);
      tick();
      data_ready = '0;
      at_neg();
      check("lat_valid_after_rise", 64'(out_valid), 64'd0);
      tick();
      at_neg();
      check("lat_valid_after_push", 64'(out_valid), 64'd1);
      check("lat_id", 64'(out_id), 64'd2);
      check("lat_data", 64'(out_data), 64'h0001_2345);
      tick();
      pop_one();
      at_neg();
      check("lat_valid_after_pop", 64'(out_valid), 64'd0);

      // 3: round-robin order
      tick();
      do_reset();
      set_sd(0, 32'hA0); set_sd(5, 32'hA5); set_sd(15, 32'hAF);
      data_ready = 16'h8021;
      exp_push(0, 32'hA0); exp_push(5, 32'hA5); exp_push(15, 32'hAF);
      tick();
      data_ready = '0;
      at_neg(); check("rr_fill_t0", 64'(fill_level), 64'd0);
      tick(); at_neg(); check("rr_fill_t1", 64'(fill_level), 64'd1);
      tick(); at_neg(); check("rr_fill_t2", 64'(fill_level), 64'd2);
      tick(); at_neg(); check("rr_fill_t3", 64'(fill_level), 64'd3);
      tick();
      rise_one(0, 32'hB0);
      exp_push(0, 32'hB0);
      set_sd(0, 32'hC0); set_sd(5, 32'hC5);
      data_ready = 16'h0021;
      exp_push(5, 32'hC5); exp_push(0, 32'hC0);
      tick();
      data_ready = '0;
      tick();
      tick();
      at_neg();
      check("rr_fill_6", 64'(fill_level), 64'd6);
      drain(20);

      // 4: full FIFO holds pending sample until a slot frees
      tick();
      do_reset();
      for (int k = 0; k < FD; k++) begin
         rise_one(k % N, 32'h100 + 32'(k));
         exp_push(k % N, 32'h100 + 32'(k));
      end
      at_neg();
      check("full_fill", 64'(fill_level), 64'd32);
      tick();
      rise_one(3, 32'h3333);
      exp_push(3, 32'h3333);
      tick();
      at_neg();
      check("full_no_push", 64'(fill_level), 64'd32);
      tick();
      pop_one();
      at_neg();
      check("full_after_pop", 64'(fill_level), 64'd31);
      tick();
      at_neg();
      check("full_refill", 64'(fill_level), 64'd32);

      // 5: overwrite while full, newest sample wins
      tick();
      rise_one(7, 32'hA);
      rise_one(7, 32'hB);
      exp_push(7, 32'hB);
      at_neg();
      check("ovw_fill", 64'(fill_level), 64'd32);
`ifdef LH_OVERRUN_COUNT_EN
      check("ovw_overrun_cnt", 64'(overrun_cnt), 64'd1);
`endif
      tick();
      pop_one();
      tick();
      at_neg();
      check("ovw_refill", 64'(fill_level), 64'd32);
      drain(40);

      // 6: masked rises, then reset during a backlog
      tick();
      enable_mask = '0;
      for (int s = 0; s < N; s++) set_sd(s, 32'hEE00 + 32'(s));
      data_ready = '1;
      tick();
      data_ready = '0;
      tick();
      tick();
      at_neg();
      check("mask_fill", 64'(fill_level), 64'd0);
      check("mask_valid", 64'(out_valid), 64'd0);
      tick();
      enable_mask = '1;
      data_ready  = 16'h03FF;
      tick();
      data_ready = '0;
      repeat (11) tick();
      at_neg();
      check("backlog_fill", 64'(fill_level), 64'd10);
      reset = 1'b1;
      exp_q.delete();
      tick();
      at_neg();
      check("midrst_fill", 64'(fill_level), 64'd0);
      check("midrst_valid", 64'(out_valid), 64'd0);
      reset = 1'b0;
      tick();
      tick();
      at_neg();
      check("post_rst_fill", 64'(fill_level), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
